// File: rtl/div_u39_u31_stream.sv
// div_u39_u31_stream: valid/ready wrapper around the pipelined unsigned divider div_u39_u31.
// Issues operands to the divider and carries tag/denominator/flags alongside its pipeline.
// Applies round-to-nearest and divide-by-zero substitution, then buffers results in a
// first-word-fall-through FIFO.
// Latency: LATENCY+1 cycles from accept edge to m_valid when the FIFO is empty.
// Backpressure: s_ready drops once in-flight + buffered results reach FIFO_DEPTH, so the FIFO
// can never overflow while m_ready is held low.
// Ports: s_* request stream in; div_* divider operands out and results in;
//        m_* result stream out; busy = anything in flight or buffered.

// Small generic FIFO, first-word-fall-through; the head entry is visible on rd_dat whenever
// rd_vld is high.
// Latency: a push becomes visible on the next cycle. Pop is rd_vld & rd_rdy.
// Backpressure: no full flag; the caller guarantees there is space before it pushes.
module div_u39_u31_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];

    assign rd_vld = (wr_ptr_q != rd_ptr_q);
    // Drive zeros when empty so downstream data outputs are clean out of reset.
    assign rd_dat = rd_vld ? mem_q[rd_ptr_q[AW-1:0]] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_vld) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (rd_vld && rd_rdy) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
        end
    end
endmodule

module div_u39_u31_stream #(
    parameter int WIDTHN     = 39,
    parameter int WIDTHD     = 31,
    parameter int LATENCY    = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WIDTHN-1:0] s_numer,
    input  logic [WIDTHD-1:0] s_denom,
    input  logic [TAG_W-1:0]  s_tag,
    input  logic              s_round,
    output logic [WIDTHN-1:0] div_numer,
    output logic [WIDTHD-1:0] div_denom,
    output logic              div_clken,
    input  logic [WIDTHN-1:0] div_quotient,
    input  logic [WIDTHD-1:0] div_remain,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTHN-1:0] m_quotient,
    output logic [WIDTHD-1:0] m_remain,
    output logic [TAG_W-1:0]  m_tag,
    output logic              m_dz,
    output logic              m_sat,
    output logic              busy
);
    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [WIDTHN-1:0] quotient;
        logic [WIDTHD-1:0] remain;
        logic [TAG_W-1:0]  tag;
        logic              dz;
        logic              sat;
    } res_t;

    // numer_lo is only loaded for divide-by-zero requests; it becomes the reported remainder.
    typedef struct packed {
        logic              vld;
        logic [TAG_W-1:0]  tag;
        logic [WIDTHD-1:0] denom;
        logic [WIDTHD-1:0] numer_lo;
        logic              rnd;
        logic              dz;
    } sb_t;

    logic              run_q, run_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic [WIDTHN-1:0] div_numer_q, div_numer_d;
    logic [WIDTHD-1:0] div_denom_q, div_denom_d;
    // Stage 0 is loaded together with the divider operands; stage LATENCY lines up with
    // div_quotient/div_remain.
    sb_t               sb_q [LATENCY+1];
    sb_t               sb_d [LATENCY+1];

    logic              accept;
    logic              pop;
    logic              in_dz;
    sb_t               sb_out;
    logic [WIDTHD:0]   rem2;
    logic              round_up;
    res_t              res;
    res_t              head;
    logic [$bits(res_t)-1:0] head_dat;

    // run_q holds s_ready and clken low while reset is active and until the first edge after it.
    assign s_ready   = run_q && (credit_q < DEPTH_C);
    assign accept    = s_valid && s_ready;
    assign pop       = m_valid && m_ready;
    assign busy      = (credit_q != '0);
    assign div_clken = run_q;
    assign div_numer = div_numer_q;
    assign div_denom = div_denom_q;
    assign in_dz     = (s_denom == '0);
    assign sb_out    = sb_q[LATENCY];

    always_comb begin
        run_d       = 1'b1;
        credit_d    = credit_q;
        div_numer_d = div_numer_q;
        div_denom_d = div_denom_q;
        if (accept && !pop) begin
            credit_d = credit_q + CW'(1);
        end else if (!accept && pop) begin
            credit_d = credit_q - CW'(1);
        end
        if (accept) begin
            div_numer_d = s_numer;
            div_denom_d = in_dz ? WIDTHD'(1) : s_denom;
        end
    end

    always_comb begin
        sb_d[0] = '0;
        if (accept) begin
            sb_d[0].vld      = 1'b1;
            sb_d[0].tag      = s_tag;
            sb_d[0].denom    = s_denom;
            sb_d[0].numer_lo = in_dz ? s_numer[WIDTHD-1:0] : '0;
            sb_d[0].rnd      = s_round;
            sb_d[0].dz       = in_dz;
        end
        for (int k = 1; k <= LATENCY; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    // Round up when the remainder is at least half the divisor; doubled at WIDTHD+1 bits so
    // the top remainder bit is not lost.
    always_comb begin
        rem2     = {div_remain, 1'b0};
        round_up = (rem2 >= {1'b0, sb_out.denom});
        res      = '0;
        res.tag  = sb_out.tag;
        res.dz   = sb_out.dz;
        if (sb_out.dz) begin
            res.quotient = '1;
            res.remain   = sb_out.numer_lo;
        end else begin
            res.quotient = div_quotient;
            res.remain   = div_remain;
            if (sb_out.rnd && round_up) begin
                if (&div_quotient) begin
                    res.sat = 1'b1;
                end else begin
                    res.quotient = div_quotient + WIDTHN'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q       <= 1'b0;
            credit_q    <= '0;
            div_numer_q <= '0;
            div_denom_q <= WIDTHD'(1);
            for (int k = 0; k <= LATENCY; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            run_q       <= run_d;
            credit_q    <= credit_d;
            div_numer_q <= div_numer_d;
            div_denom_q <= div_denom_d;
            for (int k = 0; k <= LATENCY; k++) begin
                sb_q[k] <= sb_d[k];
            end
        end
    end

    div_u39_u31_fifo #(
        .W     ($bits(res_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (sb_out.vld),
        .wr_dat (res),
        .rd_vld (m_valid),
        .rd_rdy (m_ready),
        .rd_dat (head_dat)
    );

    assign head       = res_t'(head_dat);
    assign m_quotient = head.quotient;
    assign m_remain   = head.remain;
    assign m_tag      = head.tag;
    assign m_dz       = head.dz;
    assign m_sat      = head.sat;
endmodule

// File: doc/div_u39_u31_stream.md
Name: div_u39_u31_stream

Overview:
- Streaming front/back-end around the pipelined unsigned divider div_u39_u31.
- Accepts divide requests on a valid/ready handshake and drives the divider operands with its clock enable held high.
- Carries tag, denominator and flags alongside the divider pipeline; applies optional round-to-nearest and divide-by-zero substitution.
- Buffers results in an output FIFO; credit accounting guarantees the FIFO never overflows under output backpressure.

Parameters:
- WIDTHN, 39, numerator/quotient width
- WIDTHD, 31, denominator/remainder width
- LATENCY, 8, divider pipeline latency in clk cycles (operand edge to result valid); must be >= 1
- FIFO_DEPTH, 8, output FIFO entries; power of two, >= 2
- TAG_W, 4, request tag width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- s_valid  in  1  request valid
- s_ready  out  1  request accepted when s_valid & s_ready
- s_numer  in  WIDTHN  numerator
- s_denom  in  WIDTHD  denominator
- s_tag  in  TAG_W  request tag, returned with the result
- s_round  in  1  1 = round quotient to nearest
- div_numer  out  WIDTHN  to divider numer
- div_denom  out  WIDTHD  to divider denom
- div_clken  out  1  to divider clken; constant 1 after reset
- div_quotient  in  WIDTHN  from divider
- div_remain  in  WIDTHD  from divider
- m_valid  out  1  result valid
- m_ready  in  1  result consumed when m_valid & m_ready
- m_quotient  out  WIDTHN  result quotient
- m_remain  out  WIDTHD  result remainder (unrounded)
- m_tag  out  TAG_W  echoed tag
- m_dz  out  1  divide-by-zero flag
- m_sat  out  1  rounding saturated
- busy  out  1  any request in flight or any FIFO entry occupied

Behaviour:
- Reset values:
  - s_ready=0, m_valid=0, busy=0.
  - div_numer=0, div_denom=1, div_clken=0.
  - All m_* data outputs 0; FIFO empty; credit counter 0.
  - All sideband pipeline stages invalid.
- Reset release: div_clken=1 and s_ready follows the credit rule from the first clk edge after reset deasserts.
- Credit accounting:
  - credit = in_flight + fifo_count, range 0..FIFO_DEPTH.
  - s_ready = (credit < FIFO_DEPTH), registered-free combinational.
  - credit is +1 on accept, -1 on pop; simultaneous accept and pop leaves it unchanged.
- Operand issue:
  - At accept edge E0, s_numer/s_denom are registered onto div_numer/div_denom.
  - A zero denominator is replaced by 1 on div_denom and dz is recorded.
  - With no accept, div_numer/div_denom hold their previous values.
- Sideband pipeline: {valid, tag, denom, round, dz} shift register of depth LATENCY, aligned so that stage LATENCY matches div_quotient/div_remain after edge E0+LATENCY.
- Result stage, at edge E0+LATENCY+1, writes one FIFO entry:
  - dz=1: quotient = all ones, remain = numer[WIDTHD-1:0] (numer carried in sideband only when dz), m_sat=0.
  - round=1 and dz=0: if 2*remain >= denom (compare at WIDTHD+1 bits), quotient+1. If quotient was all ones, it stays all ones and sat=1.
  - Otherwise quotient/remain pass through, sat=0.
- Latency: m_valid rises LATENCY+1 cycles after the accept edge when the FIFO is empty and m_ready=1.
- Throughput: one request per cycle sustained while m_ready=1.
- FIFO behaviour:
  - First-word-fall-through; m_* driven from the head entry.
  - Push and pop in the same cycle are allowed, including when full or when empty-with-push (the head appears next cycle).
  - Overflow is impossible by the credit rule.
- Ordering: results leave strictly in request order.
- busy = (credit != 0).
- Reset mid-operation: all in-flight and buffered results are discarded; none reappear after release.

Test Plan:
- LATENCY=8, m_ready=1, request (8,3,tag=5,round=0) -> m_valid 9 cycles after accept; quotient=2, remain=2, tag=5, dz=0.
- Request (15,4,round=1) -> quotient=4, remain=3, sat=0. Request (13,12,round=1) -> quotient=1, remain=1.
- Request numer=100, denom=0 -> m_dz=1, quotient=0x7F_FFFF_FFFF, remain=100, sat=0.
- Request numer=all ones, denom=1, round=1 -> quotient all ones (remain 0, no increment, sat=0).
- Hold m_ready=0, stream requests back-to-back -> exactly 8 accepted, then s_ready=0. Release m_ready -> 8 results in tag order; s_ready returns the cycle after the first pop.
- Assert reset with 3 in flight and 2 buffered -> m_valid=0 and busy=0 immediately; no results emitted after release.
